// File: rtl/regwrite_trace_uart.sv
// ---------------------------------------------------------------------------
// regwrite_trace_uart
//
// Debug trace tap for the register-file write port of the franken_riscv core.
// Every qualified register write (strobed by i_sample) is captured as a
// {rd, data} record into a small FIFO. Records are then streamed out as
// fixed 6-byte frames on an 8N1 UART line:
//     0xA5, {3'b000, rd}, data[7:0], data[15:8], data[23:16], data[31:24]
// Bytes and frames are sent back-to-back with no idle gap. The core is never
// stalled; when the FIFO is full, records are dropped and counted instead.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (2..65535)
//   FIFO_DEPTH    record FIFO entries, power of two (2..256)
//
// Ports:
//   i_clk        single clock for the whole block
//   i_reset      asynchronous, active-high reset
//   i_sample     one-cycle capture strobe; write signals are looked at only
//                while it is high
//   i_reg_write  register-file write enable from the core
//   i_rd         destination register index
//   i_write_reg  data being written to rd
//   o_txd        UART serial output, idle high
//   o_busy       high while a frame is in flight or records are queued
//   o_overflow   sticky flag, set when a record is dropped (FIFO full)
//   o_drop_cnt   saturating count of dropped records
// ---------------------------------------------------------------------------
module regwrite_trace_uart #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_sample,
    input  logic        i_reg_write,
    input  logic [4:0]  i_rd,
    input  logic [31:0] i_write_reg,
    output logic        o_txd,
    output logic        o_busy,
    output logic        o_overflow,
    output logic [7:0]  o_drop_cnt
);

    localparam int          AW          = $clog2(FIFO_DEPTH);
    localparam logic [15:0] BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);
    localparam logic [7:0]  SYNC_BYTE   = 8'hA5;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // Record FIFO storage and pointers. Pointers carry one extra wrap bit so
    // that full and empty can be told apart without an occupancy counter.
    logic [36:0] r_mem [FIFO_DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;

    logic        w_empty;
    logic        w_full;
    logic        w_capture;
    logic        w_push;
    logic        w_drop;
    logic        w_pop;
    logic [36:0] w_fifo_rdata;

    // Transmitter state
    state_t      r_state;
    logic [15:0] r_baud;
    logic [2:0]  r_bit_idx;
    logic [2:0]  r_byte_idx;
    logic [7:0]  r_shift;
    logic [36:0] r_rec;

    state_t      w_state_nxt;
    logic [15:0] w_baud_nxt;
    logic [2:0]  w_bit_idx_nxt;
    logic [2:0]  w_byte_idx_nxt;
    logic [7:0]  w_shift_nxt;
    logic [36:0] w_rec_nxt;

    // Overflow bookkeeping
    logic        r_overflow;
    logic [7:0]  r_drop_cnt;

    // Picks the byte of a frame for a given position in the frame.
    function automatic logic [7:0] frameByte(input logic [36:0] rec,
                                             input logic [2:0]  idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = SYNC_BYTE;
            3'd1:    b = {3'b000, rec[36:32]};
            3'd2:    b = rec[7:0];
            3'd3:    b = rec[15:8];
            3'd4:    b = rec[23:16];
            default: b = rec[31:24];
        endcase
        return b;
    endfunction

    assign w_empty      = (r_wptr == r_rptr);
    assign w_full       = (r_wptr[AW] != r_rptr[AW]) &&
                          (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_fifo_rdata = r_mem[r_rptr[AW-1:0]];

    // Writes to x0 are architecturally invisible and never logged. Fullness
    // is judged on the pre-edge pointers, so a pop on the same edge does not
    // make room for this push.
    assign w_capture = i_sample && i_reg_write && (i_rd != 5'd0);
    assign w_push    = w_capture && !w_full;
    assign w_drop    = w_capture && w_full;

    // FIFO storage has no reset; stale contents are unreachable once the
    // pointers are cleared.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= {i_rd, i_write_reg};
        end
    end

    // FIFO pointers: push and pop are independent, so a simultaneous push and
    // pop leaves the occupancy unchanged.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // Sticky overflow flag and saturating drop counter; only reset clears them.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= 8'd0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != 8'hFF) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    // Transmitter state register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_baud     <= 16'd0;
            r_bit_idx  <= 3'd0;
            r_byte_idx <= 3'd0;
            r_shift    <= 8'd0;
            r_rec      <= 37'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_baud     <= w_baud_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_byte_idx <= w_byte_idx_nxt;
            r_shift    <= w_shift_nxt;
            r_rec      <= w_rec_nxt;
        end
    end

    // Transmitter next-state logic. The baud counter counts down and a bit
    // boundary is the cycle where it reaches zero; it is reloaded on every
    // boundary. From STOP the next byte, or the next record, starts straight
    // away so that frames leave with no idle gap.
    always_comb begin
        w_state_nxt    = r_state;
        w_baud_nxt     = r_baud;
        w_bit_idx_nxt  = r_bit_idx;
        w_byte_idx_nxt = r_byte_idx;
        w_shift_nxt    = r_shift;
        w_rec_nxt      = r_rec;
        w_pop          = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop          = 1'b1;
                    w_rec_nxt      = w_fifo_rdata;
                    w_byte_idx_nxt = 3'd0;
                    w_shift_nxt    = SYNC_BYTE;
                    w_baud_nxt     = BAUD_RELOAD;
                    w_state_nxt    = START;
                end
            end

            START: begin
                if (r_baud == 16'd0) begin
                    w_baud_nxt    = BAUD_RELOAD;
                    w_bit_idx_nxt = 3'd0;
                    w_state_nxt   = DATA;
                end else begin
                    w_baud_nxt = r_baud - 16'd1;
                end
            end

            DATA: begin
                if (r_baud == 16'd0) begin
                    w_baud_nxt  = BAUD_RELOAD;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_baud_nxt = r_baud - 16'd1;
                end
            end

            STOP: begin
                if (r_baud == 16'd0) begin
                    w_baud_nxt = BAUD_RELOAD;
                    if (r_byte_idx < 3'd5) begin
                        w_byte_idx_nxt = r_byte_idx + 3'd1;
                        w_shift_nxt    = frameByte(r_rec, r_byte_idx + 3'd1);
                        w_state_nxt    = START;
                    end else if (!w_empty) begin
                        w_pop          = 1'b1;
                        w_rec_nxt      = w_fifo_rdata;
                        w_byte_idx_nxt = 3'd0;
                        w_shift_nxt    = SYNC_BYTE;
                        w_state_nxt    = START;
                    end else begin
                        w_baud_nxt  = 16'd0;
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_baud_nxt = r_baud - 16'd1;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Line level is decoded straight from registered state, so reset forces
    // the line high immediately.
    always_comb begin
        o_txd = 1'b1;
        unique case (r_state)
            START:   o_txd = 1'b0;
            DATA:    o_txd = r_shift[0];
            default: o_txd = 1'b1;
        endcase
    end

    assign o_busy     = (r_state != IDLE) || !w_empty;
    assign o_overflow = r_overflow;
    assign o_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_regwrite_trace_uart.sv
// ---------------------------------------------------------------------------
// tb_regwrite_trace_uart
//
// Self-checking bench for regwrite_trace_uart with CLKS_PER_BIT=4 and
// FIFO_DEPTH=4. Stimulus pushes the bytes it expects to see on the wire into
// a scoreboard queue; an independent UART receiver decodes txd and pops and
// compares each byte as it arrives. The main thread additionally checks
// reset values, latency, frame durations and the overflow bookkeeping.
// ---------------------------------------------------------------------------
module tb_regwrite_trace_uart;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        sample = 1'b0;
    logic        regWrite = 1'b0;
    logic [4:0]  rd = 5'd0;
    logic [31:0] writeReg = 32'd0;
    logic        txd;
    logic        busy;
    logic        overflow;
    logic [7:0]  dropCnt;

    int          compared = 0;
    int          mismatched = 0;
    int          cyc = 0;
    logic [7:0]  expQ [$];

    regwrite_trace_uart #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .i_clk       (clock),
        .i_reset     (reset),
        .i_sample    (sample),
        .i_reg_write (regWrite),
        .i_rd        (rd),
        .i_write_reg (writeReg),
        .o_txd       (txd),
        .o_busy      (busy),
        .o_overflow  (overflow),
        .o_drop_cnt  (dropCnt)
    );

    // Free-running clock and an edge counter used to time-align stimulus.
    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc <= cyc + 1;
    end

    // One comparison: counts it, and reports it when it disagrees.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d",
                     name, actual, expected, cyc);
        end
    endtask

    // Expected wire bytes for one logged record.
    task automatic pushFrame(input logic [4:0] r, input logic [31:0] d);
        expQ.push_back(8'hA5);
        expQ.push_back({3'b000, r});
        expQ.push_back(d[7:0]);
        expQ.push_back(d[15:8]);
        expQ.push_back(d[23:16]);
        expQ.push_back(d[31:24]);
    endtask

    // Drives one sample strobe for the next rising edge. Called just after a
    // falling edge; returns at the following falling edge.
    task automatic applyStimulus(input logic [4:0] r, input logic [31:0] d,
                                 input bit logged);
        sample   = 1'b1;
        regWrite = 1'b1;
        rd       = r;
        writeReg = d;
        if (logged) begin
            pushFrame(r, d);
        end
        @(negedge clock);
        sample   = 1'b0;
        regWrite = 1'b0;
    endtask

    // Waits on falling edges until busy drops, bounded by maxCycles.
    task automatic waitBusyLow(input string name, input int maxCycles,
                               output int endCyc);
        int n;
        n = 0;
        while (busy && n < maxCycles) begin
            @(negedge clock);
            n++;
        end
        endCyc = cyc;
        checkOutput(name, 32'(busy), 32'd0);
    endtask

    // Receiver helper: waits n falling edges and flags any reset seen.
    task automatic waitNeg(input int n, output bit aborted);
        aborted = 1'b0;
        repeat (n) begin
            @(negedge clock);
            if (reset) begin
                aborted = 1'b1;
            end
        end
    endtask

    // UART receiver and scoreboard checker. A start bit is detected half a
    // cycle in; every later sample lands 2.5 cycles into its bit.
    initial begin : monitor
        logic [7:0] b;
        logic [7:0] want;
        bit         ab;
        b = 8'd0;
        forever begin
            @(negedge clock);
            if (!reset && txd === 1'b0) begin
                waitNeg(2, ab);
                if (!ab) begin
                    checkOutput("start_bit", 32'(txd), 32'd0);
                end
                for (int i = 0; i < 8; i++) begin
                    if (!ab) begin
                        waitNeg(4, ab);
                        b[i] = txd;
                    end
                end
                if (!ab) begin
                    waitNeg(4, ab);
                end
                if (!ab) begin
                    checkOutput("stop_bit", 32'(txd), 32'd1);
                    if (expQ.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("[TB] FAIL unexpected_byte: got 0x%0h, expected no byte at cycle %0d",
                                 b, cyc);
                    end else begin
                        want = expQ.pop_front();
                        checkOutput("frame_byte", 32'(b), 32'(want));
                    end
                end
            end
        end
    end

    // Directed scenarios.
    initial begin : stimulus
        int  startEdge;
        int  endCyc;
        bit  sawLow;
        bit  sawBusy;

        // Reset values while reset is held from time zero.
        #1;
        checkOutput("rst_txd", 32'(txd), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        checkOutput("rst_drop_cnt", 32'(dropCnt), 32'd0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);

        // Single write: rd=5, data=DEADBEEF.
        $display("[TB] single write");
        expQ.push_back(8'hA5);
        expQ.push_back(8'h05);
        expQ.push_back(8'hEF);
        expQ.push_back(8'hBE);
        expQ.push_back(8'hAD);
        expQ.push_back(8'hDE);
        startEdge = cyc + 1;
        applyStimulus(5'd5, 32'hDEADBEEF, 1'b0);
        checkOutput("txd_before_pop", 32'(txd), 32'd1);
        checkOutput("busy_after_push", 32'(busy), 32'd1);
        @(negedge clock);
        checkOutput("txd_fall", 32'(txd), 32'd0);
        waitBusyLow("single_busy_timeout", 1000, endCyc);
        checkOutput("single_frame_cycles", 32'(endCyc - (startEdge + 1)), 32'd240);
        checkOutput("single_txd_idle", 32'(txd), 32'd1);
        checkOutput("single_sb_drained", 32'(expQ.size()), 32'd0);

        // Writes to x0 are not logged.
        $display("[TB] x0 filter");
        applyStimulus(5'd0, 32'h12345678, 1'b0);
        sawLow  = 1'b0;
        sawBusy = 1'b0;
        repeat (20) begin
            if (txd !== 1'b1) sawLow = 1'b1;
            if (busy !== 1'b0) sawBusy = 1'b1;
            @(negedge clock);
        end
        checkOutput("x0_txd_low", 32'(sawLow), 32'd0);
        checkOutput("x0_busy", 32'(sawBusy), 32'd0);

        // Back-to-back: three frames, no gap, 720 cycles from first fall.
        $display("[TB] back-to-back");
        startEdge = cyc + 1;
        applyStimulus(5'd1, 32'h00000011, 1'b1);
        applyStimulus(5'd2, 32'h00000022, 1'b1);
        applyStimulus(5'd3, 32'h00000033, 1'b1);
        waitBusyLow("b2b_busy_timeout", 2000, endCyc);
        checkOutput("b2b_cycles", 32'(endCyc - (startEdge + 1)), 32'd720);
        checkOutput("b2b_sb_drained", 32'(expQ.size()), 32'd0);
        checkOutput("pre_ovf_overflow", 32'(overflow), 32'd0);

        // Overflow: 7 samples while idle -> 1 popped, 4 queued, 2 dropped.
        $display("[TB] overflow");
        startEdge = cyc + 1;
        for (int k = 1; k <= 7; k++) begin
            applyStimulus(5'(k), 32'hA000_0000 + 32'(k), k <= 5);
        end
        checkOutput("ovf_overflow", 32'(overflow), 32'd1);
        checkOutput("ovf_drop_cnt", 32'(dropCnt), 32'd2);
        waitBusyLow("ovf_busy_timeout", 2000, endCyc);
        checkOutput("ovf_five_frames_cycles", 32'(endCyc - (startEdge + 1)), 32'd1200);
        checkOutput("ovf_sb_drained", 32'(expQ.size()), 32'd0);

        // Fill the FIFO, then sample on the edge where STOP pops the next
        // record: the FIFO is still full before that pop, so it is dropped.
        $display("[TB] full plus pop");
        startEdge = cyc + 1;
        for (int k = 8; k <= 12; k++) begin
            applyStimulus(5'(k), 32'hB000_0000 + 32'(k), 1'b1);
        end
        while (cyc + 1 < startEdge + 241) begin
            @(negedge clock);
        end
        checkOutput("pre_full_pop_drop_cnt", 32'(dropCnt), 32'd2);
        applyStimulus(5'd13, 32'hF00D0000, 1'b0);
        checkOutput("full_pop_drop_cnt", 32'(dropCnt), 32'd3);

        // Keep sampling: only the cycles right after a pop get in (offsets 1
        // and 241); the other 297 are drops and the counter saturates.
        $display("[TB] drop saturation");
        for (int i = 1; i < 300; i++) begin
            applyStimulus(5'd14, 32'hC000_0000 | 32'(i), (i == 1) || (i == 241));
        end
        checkOutput("sat_drop_cnt", 32'(dropCnt), 32'd255);
        checkOutput("sat_overflow", 32'(overflow), 32'd1);
        checkOutput("sat_busy", 32'(busy), 32'd1);

        // Reset mid-frame: outputs clear at once, queued records are lost.
        $display("[TB] reset mid-frame");
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midrst_txd", 32'(txd), 32'd1);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_overflow", 32'(overflow), 32'd0);
        checkOutput("midrst_drop_cnt", 32'(dropCnt), 32'd0);
        expQ.delete();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        sawLow  = 1'b0;
        sawBusy = 1'b0;
        repeat (60) begin
            @(negedge clock);
            if (txd !== 1'b1) sawLow = 1'b1;
            if (busy !== 1'b0) sawBusy = 1'b1;
        end
        checkOutput("postrst_txd_low", 32'(sawLow), 32'd0);
        checkOutput("postrst_busy", 32'(sawBusy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/regwrite_trace_uart.md
# regwrite_trace_uart

Debug trace block that sits downstream of the franken_riscv core's register-file write port. On each qualified register write it captures the destination register index and write data into a small FIFO. It then serialises each record as a fixed 6-byte frame over an 8N1 UART line. Pin `txd` drives the board TX pin, giving a cycle-independent log of architectural register updates without stalling the core.

## Interface
Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (434 = 50 MHz / 115200); legal range 2..65535
- FIFO_DEPTH, 16, record FIFO entries; power of two, 2..256

Ports:
- clk  in  1  single clock for the whole block
- reset  in  1  asynchronous, active-high reset
- sample  in  1  one-cycle capture strobe; register-write signals are examined only on cycles where it is high
- reg_write  in  1  register-file write enable from the core
- rd  in  5  destination register index
- write_reg  in  32  data being written to rd
- txd  out  1  UART serial output, idle high
- busy  out  1  high while a frame is in flight or the FIFO is non-empty
- overflow  out  1  sticky; set when a record is dropped because the FIFO is full
- drop_cnt  out  8  saturating count of dropped records

## Operation
- Capture: on a rising clk edge with sample && reg_write && rd != 0, push {rd, write_reg} (37 bits) into the FIFO. Writes to x0 are never logged.
- Full FIFO: the push is discarded, overflow is set to 1, and drop_cnt increments, saturating at 255.
  - Fullness is evaluated before any same-cycle pop, so a push on a full FIFO is dropped even if a pop occurs on the same edge.
- Frame format, byte order on the wire:
  - 0xA5
  - {3'b000, rd}
  - write_reg[7:0], write_reg[15:8], write_reg[23:16], write_reg[31:24]
- Byte format: start bit (0), 8 data bits LSB first, stop bit (1).
- Frames are back-to-back. There is no idle gap between bytes of a frame or between consecutive frames.
- TX FSM:
  - IDLE: txd=1. If the FIFO is non-empty, pop it into a 37-bit record register, set byte_idx=0, load byte 0, and go to START.
  - START: txd=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: txd=shift[0] for CLKS_PER_BIT cycles per bit, shifting right after each bit. After bit 7, go to STOP.
  - STOP: txd=1 for CLKS_PER_BIT cycles, then:
    - if byte_idx<5: increment byte_idx, load the next byte, and go to START;
    - else if the FIFO is non-empty: pop, set byte_idx=0, load byte 0, and go to START;
    - else go to IDLE.
- The baud counter is a 16-bit down-counter, reloaded with CLKS_PER_BIT-1 on every bit boundary.
- busy = (state != IDLE) || !fifo_empty.
- overflow and drop_cnt clear only on reset.

## Timing
- Reset values (asserted asynchronously, immediate):
  - txd=1, busy=0, overflow=0, drop_cnt=0
  - FIFO empty, FSM in IDLE, all counters at 0
- Capture latency: a push on edge N makes the FIFO non-empty after N. If the FSM is in IDLE, the pop happens on edge N+1 and txd goes low after edge N+1.
- Frame duration: exactly 60*CLKS_PER_BIT cycles (6 bytes x 10 bits).
- A bit boundary occurs every CLKS_PER_BIT cycles; txd changes only on bit boundaries and on the IDLE->START transition.
- Throughput: capture is 1 record/cycle into the FIFO. Sustained drain is 1 record per 60*CLKS_PER_BIT cycles.
- Simultaneous push and pop on a non-full FIFO: both take effect and the occupancy is unchanged.
- Pointer wrap-around: read and write pointers are log2(FIFO_DEPTH)+1 bits wide. Full when the MSBs differ and the rest are equal; empty when all bits are equal.
- Reset mid-frame: txd returns to 1 immediately, any partially sent byte is abandoned, and all queued records are lost.
- sample/reg_write/rd/write_reg are sampled only on clk edges. The integrator must make sample high for exactly one clk cycle per core write.

## Test plan
Bench uses CLKS_PER_BIT=4, FIFO_DEPTH=4.
- Reset: assert reset mid-run -> txd=1, busy=0, overflow=0, drop_cnt=0 within the same cycle; after release, txd stays 1 with no activity.
- Single write: sample with rd=5, write_reg=0xDEADBEEF -> txd falls 1 cycle later. The decoded bytes are A5 05 EF BE AD DE, busy drops 240 cycles after the fall, and txd is left at 1.
- x0 filter: sample with rd=0, write_reg=0x12345678 -> no push, txd stays 1, busy stays 0.
- Back-to-back: 3 samples on consecutive cycles (rd=1,2,3; data=0x11,0x22,0x33) -> three frames are emitted in order with no idle gap, 720 cycles total.
- Overflow: 7 consecutive samples while idle -> the first pops immediately, 4 are queued, and 2 are dropped. Result: overflow=1, drop_cnt=2, and exactly 5 frames are emitted. Then 300 more drops -> drop_cnt saturates at 255.
- Full plus pop same edge: with the FIFO full, a sample coinciding with the STOP->START pop -> the record is dropped and drop_cnt increments by 1.
